freq_discriminator: RTL and testbench

Recovers the Doppler frequency word from a complex I/Q tone. This is the inverse of the NCO: 2's-comp I/Q samples in, 32-bit phase-increment word out, scaled so that a full circle is 2^32. It sits on the DRFM receive/calibration path and supports loopback checks of the frequency-shift chain. It uses an iterative CORDIC vectoring engine, a phase differencer, and an optional block averager.

---
 rtl/freq_discriminator_if.sv | 25 ++
 rtl/freq_discriminator.sv | 199 +++++++++++++++++++
 tb/tb_freq_discriminator.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_discriminator_if.sv
// Sample/result bundle for freq_discriminator.
// mag_out is present only when FREQ_DISC_MAG_OUT_EN is defined.
interface freq_discriminator_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [16:0] i_in;
    logic signed [16:0] q_in;
    logic        [31:0] phase_out;
    logic               phase_strobe;
    logic        [31:0] freq_out;
    logic               freq_valid;
`ifdef FREQ_DISC_MAG_OUT_EN
    logic        [19:0] mag_out;

    modport master (output in_valid, i_in, q_in,
                    input  in_ready, phase_out, phase_strobe, freq_out, freq_valid, mag_out);
    modport slave  (input  in_valid, i_in, q_in,
                    output in_ready, phase_out, phase_strobe, freq_out, freq_valid, mag_out);
`else
    modport master (output in_valid, i_in, q_in,
                    input  in_ready, phase_out, phase_strobe, freq_out, freq_valid);
    modport slave  (input  in_valid, i_in, q_in,
                    output in_ready, phase_out, phase_strobe, freq_out, freq_valid);
`endif
endinterface

// File: rtl/freq_discriminator.sv
// I/Q -> phase (iterative CORDIC vectoring) -> phase difference -> optional block average.
// Define FREQ_DISC_MAG_OUT_EN to add mag_out and gate low-magnitude samples out of the differencer.
//
// state   | meaning
// IDLE    | ready; sample accepted on in_valid
// PREROT  | fold left half-plane onto the right, seed z
// ITERATE | ITER micro-rotations driving y to zero
// DONE    | publish phase, run differencer/averager
module freq_discriminator #(
    parameter int ITER     = 16,
    parameter int AVG_LOG2 = 0
) (
    input  logic M100CLK,
    input  logic reset,
    freq_discriminator_if.slave bus
);
    localparam int SUM_W = 32 + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, PREROT, ITERATE, DONE} state_t;

    state_t state, state_nxt;

    logic signed [19:0] x, y;
    logic        [31:0] z;
    logic        [4:0]  iter_cnt;
    logic               zero_in;
    logic        [31:0] phase_r, freq_r, prev_phase;
    logic               phase_stb_r, freq_vld_r, primed;
    logic signed [SUM_W-1:0] avg_sum;
    logic        [CNT_W-1:0] avg_cnt;

    logic               in_ready_c, accept, load, step, done;
    logic        [4:0]  shift_idx;
    logic signed [19:0] x_sh, y_sh;
    logic        [31:0] z_fin;
    logic signed [31:0] d;
    logic signed [SUM_W-1:0] sum_nxt;
    logic        [31:0] avg_q;
    logic               sample_ok;

    function automatic logic [31:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:    atan_lut = 32'h2000_0000;
            5'd1:    atan_lut = 32'h12E4_051E;
            5'd2:    atan_lut = 32'h09FB_385B;
            5'd3:    atan_lut = 32'h0511_11D4;
            5'd4:    atan_lut = 32'h028B_0D43;
            5'd5:    atan_lut = 32'h0145_D7E1;
            5'd6:    atan_lut = 32'h00A2_F61E;
            5'd7:    atan_lut = 32'h0051_7C55;
            5'd8:    atan_lut = 32'h0028_BE53;
            5'd9:    atan_lut = 32'h0014_5F2F;
            5'd10:   atan_lut = 32'h000A_2F98;
            5'd11:   atan_lut = 32'h0005_17CC;
            5'd12:   atan_lut = 32'h0002_8BE6;
            5'd13:   atan_lut = 32'h0001_45F3;
            5'd14:   atan_lut = 32'h0000_A2FA;
            5'd15:   atan_lut = 32'h0000_517D;
            5'd16:   atan_lut = 32'h0000_28BE;
            5'd17:   atan_lut = 32'h0000_145F;
            5'd18:   atan_lut = 32'h0000_0A30;
            5'd19:   atan_lut = 32'h0000_0518;
            default: atan_lut = 32'h0000_0000;
        endcase
    endfunction

    always_ff @(posedge M100CLK) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = PREROT;
            PREROT:  state_nxt = ITERATE;
            ITERATE: if (iter_cnt == 5'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:    in_ready_c = 1'b1;
            PREROT:  load       = 1'b1;
            ITERATE: step       = 1'b1;
            DONE:    done       = 1'b1;
            default: ;
        endcase
        accept = in_ready_c & bus.in_valid;
    end

    // iter_cnt counts down, so the shift index is recovered from it
    assign shift_idx = 5'(ITER - 1) - iter_cnt;
    assign x_sh      = x >>> shift_idx;
    assign y_sh      = y >>> shift_idx;

    // CORDIC wanders off zero for a (0,0) input, so force that case
    assign z_fin   = zero_in ? 32'h0 : z;
    assign d       = signed'(z_fin - prev_phase);
    assign sum_nxt = avg_sum + SUM_W'(d);
    assign avg_q   = 32'(sum_nxt >>> AVG_LOG2);

`ifdef FREQ_DISC_MAG_OUT_EN
    assign sample_ok = ($unsigned(x) >= 20'd16);
`else
    assign sample_ok = 1'b1;
`endif

    always_ff @(posedge M100CLK) begin
        if (!reset) begin
            x           <= '0;
            y           <= '0;
            z           <= '0;
            iter_cnt    <= '0;
            zero_in     <= 1'b0;
            phase_r     <= '0;
            freq_r      <= '0;
            prev_phase  <= '0;
            phase_stb_r <= 1'b0;
            freq_vld_r  <= 1'b0;
            primed      <= 1'b0;
            avg_sum     <= '0;
            avg_cnt     <= '0;
        end else begin
            phase_stb_r <= 1'b0;
            freq_vld_r  <= 1'b0;
            if (accept) begin
                x       <= 20'(bus.i_in);
                y       <= 20'(bus.q_in);
                zero_in <= (bus.i_in == 17'sd0) && (bus.q_in == 17'sd0);
            end
            if (load) begin
                iter_cnt <= 5'(ITER - 1);
                if (x[19]) begin
                    x <= -x;
                    y <= -y;
                    z <= 32'h8000_0000;
                end else begin
                    z <= 32'h0;
                end
            end
            if (step) begin
                iter_cnt <= iter_cnt - 5'd1;
                if (!y[19]) begin
                    x <= x + y_sh;
                    y <= y - x_sh;
                    z <= z + atan_lut(shift_idx);
                end else begin
                    x <= x - y_sh;
                    y <= y + x_sh;
                    z <= z - atan_lut(shift_idx);
                end
            end
            if (done) begin
                phase_r     <= z_fin;
                phase_stb_r <= 1'b1;
                if (sample_ok) begin
                    prev_phase <= z_fin;
                    if (!primed) begin
                        primed <= 1'b1;
                    end else if (avg_cnt == CNT_LAST) begin
                        freq_r     <= avg_q;
                        freq_vld_r <= 1'b1;
                        avg_sum    <= '0;
                        avg_cnt    <= '0;
                    end else begin
                        avg_sum <= sum_nxt;
                        avg_cnt <= avg_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

`ifdef FREQ_DISC_MAG_OUT_EN
    logic [19:0] mag_r;

    always_ff @(posedge M100CLK) begin
        if (!reset)    mag_r <= '0;
        else if (done) mag_r <= $unsigned(x);
    end

    assign bus.mag_out = mag_r;
`endif

    assign bus.in_ready     = in_ready_c;
    assign bus.phase_out    = phase_r;
    assign bus.phase_strobe = phase_stb_r;
    assign bus.freq_out     = freq_r;
    assign bus.freq_valid   = freq_vld_r;
endmodule

// File: tb/tb_freq_discriminator.sv
// Directed bench for freq_discriminator: two instances (AVG_LOG2=0 and 2) share stimulus.
module tb_freq_discriminator;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    freq_discriminator_if b0 ();
    freq_discriminator_if b2 ();

    freq_discriminator #(.ITER(16), .AVG_LOG2(0)) dut0 (.M100CLK(clk), .reset(reset), .bus(b0.slave));
    freq_discriminator #(.ITER(16), .AVG_LOG2(2)) dut2 (.M100CLK(clk), .reset(reset), .bus(b2.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                           input longint tol);
        logic signed [31:0] diff;
        longint             dl;
        diff = signed'(obs - exp);
        dl   = longint'(diff);
        if (dl < 0) dl = -dl;
        n_checks++;
        assert ((dl <= tol) === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h +/- %0d", tag, obs, exp, tol);
        end
    endtask

    task automatic drive(input logic iv, input logic signed [16:0] i, input logic signed [16:0] q);
        b0.in_valid = iv; b0.i_in = i; b0.q_in = q;
        b2.in_valid = iv; b2.i_in = i; b2.q_in = q;
    endtask

    task automatic nco_iq(input logic [31:0] ph, output logic signed [16:0] i,
                          output logic signed [16:0] q);
        real a;
        a = 2.0 * 3.141592653589793 * real'(ph) / 4294967296.0;
        i = 17'($rtoi(30000.0 * $cos(a)));
        q = 17'($rtoi(30000.0 * $sin(a)));
    endtask

    // one sample through both DUTs; lat = negedges from accept edge to strobe
    task automatic send(input logic signed [16:0] i, input logic signed [16:0] q,
                        output int lat, output logic [31:0] ph,
                        output logic fv0, output logic [31:0] fo0,
                        output logic fv2, output logic [31:0] fo2);
        int n;
        @(negedge clk);
        drive(1'b1, i, q);
        n = 0;
        while (b0.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        assert (n < 50) else begin
            n_fail++;
            $error("FAIL accept_timeout: waited %0d cycles, limit 50", n);
        end
        @(negedge clk);
        drive(1'b0, 17'sd0, 17'sd0);
        lat = 1;
        while (b0.phase_strobe !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        assert (lat < 40) else begin
            n_fail++;
            $error("FAIL strobe_timeout: waited %0d cycles, limit 40", lat);
        end
        ph  = b0.phase_out;
        fv0 = b0.freq_valid;
        fo0 = b0.freq_out;
        fv2 = b2.freq_valid;
        fo2 = b2.freq_out;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] ph, fo0, fo2, nph;
        logic        fv0, fv2;
        logic signed [16:0] si, sq;
        int          acc_t[$];
        int          str_t[$];
        int          low_cnt, strobes;

        reset = 1'b0;
        drive(1'b0, 17'sd0, 17'sd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(b0.in_ready), 32'd1);
        chk("rst_phase_out", b0.phase_out, 32'h0);
        chk("rst_freq_out", b0.freq_out, 32'h0);
        chk("rst_phase_strobe", 32'(b0.phase_strobe), 32'd0);
        chk("rst_freq_valid", 32'(b0.freq_valid), 32'd0);
        chk("rst_freq_out_avg", b2.freq_out, 32'h0);
`ifdef FREQ_DISC_MAG_OUT_EN
        chk("rst_mag_out", 32'(b0.mag_out), 32'h0);
`endif

        // repeated DC tone on +I axis
        send(17'sd65535, 17'sd0, lat, ph, fv0, fo0, fv2, fo2);
        chk("dc1_latency", 32'(lat), 32'd19);
        chk_tol("dc1_phase", ph, 32'h0, 131072);
        chk("dc1_no_freq_valid", 32'(fv0), 32'd0);
        for (int k = 2; k <= 3; k++) begin
            send(17'sd65535, 17'sd0, lat, ph, fv0, fo0, fv2, fo2);
            chk_tol($sformatf("dc%0d_phase", k), ph, 32'h0, 131072);
            chk($sformatf("dc%0d_freq_valid", k), 32'(fv0), 32'd1);
            chk_tol($sformatf("dc%0d_freq", k), fo0, 32'h0, 131072);
        end

        // quadrants, each a quarter turn after the previous one
        send(17'sd0, 17'sd32767, lat, ph, fv0, fo0, fv2, fo2);
        chk_tol("quad_90_phase", ph, 32'h4000_0000, 131072);
        chk_tol("quad_90_freq", fo0, 32'h4000_0000, 262144);
        send(-17'sd32767, 17'sd0, lat, ph, fv0, fo0, fv2, fo2);
        chk_tol("quad_180_phase", ph, 32'h8000_0000, 131072);
        chk_tol("quad_180_freq", fo0, 32'h4000_0000, 262144);
        send(17'sd0, -17'sd32767, lat, ph, fv0, fo0, fv2, fo2);
        chk_tol("quad_270_phase", ph, 32'hC000_0000, 131072);
        chk_tol("quad_270_freq", fo0, 32'h4000_0000, 262144);
        send(17'sd0, 17'sd0, lat, ph, fv0, fo0, fv2, fo2);
        chk("zero_in_phase", ph, 32'h0);
`ifdef FREQ_DISC_MAG_OUT_EN
        chk("zero_in_gated", 32'(fv0), 32'd0);
`else
        chk("zero_in_freq_valid", 32'(fv0), 32'd1);
        chk_tol("zero_in_freq", fo0, 32'h4000_0000, 262144);
`endif
        send(-17'sd65536, 17'sd0, lat, ph, fv0, fo0, fv2, fo2);
        chk_tol("neg_fullscale_phase", ph, 32'h8000_0000, 131072);

        // NCO loopback, positive then negative shift across the wrap
        nph = 32'h0;
        for (int k = 0; k < 5; k++) begin
            nco_iq(nph, si, sq);
            send(si, sq, lat, ph, fv0, fo0, fv2, fo2);
            if (k > 0) chk_tol($sformatf("nco_pos_freq%0d", k), fo0, 32'h0100_0000, 2097152);
            nph = nph + 32'h0100_0000;
        end
        nph = 32'h0200_0000;
        for (int k = 0; k < 6; k++) begin
            nco_iq(nph, si, sq);
            send(si, sq, lat, ph, fv0, fo0, fv2, fo2);
            if (k > 0) chk_tol($sformatf("nco_neg_freq%0d", k), fo0, 32'hFF00_0000, 2097152);
            nph = nph + 32'hFF00_0000;
        end

        // back-pressure: in_valid held high; data at 90 deg only when ready
        low_cnt = 0;
        strobes = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (b0.phase_strobe === 1'b1) begin
                str_t.push_back(t);
                strobes++;
                chk_tol($sformatf("bp_phase%0d", strobes), b0.phase_out, 32'h4000_0000, 131072);
            end
            if (b0.in_ready === 1'b1) begin
                acc_t.push_back(t);
                drive(1'b1, 17'sd0, 17'sd32767);
            end else begin
                if (acc_t.size() == 1) low_cnt++;
                drive(1'b1, 17'sd0, -17'sd32767);
            end
        end
        @(negedge clk);
        drive(1'b0, 17'sd0, 17'sd0);
        chk("bp_accepts", 32'(acc_t.size()), 32'd4);
        chk("bp_strobes", 32'(strobes), 32'd3);
        chk("bp_ready_low", 32'(low_cnt), 32'd18);
        if (acc_t.size() >= 2) chk("bp_accept_gap", 32'(acc_t[1] - acc_t[0]), 32'd19);
        else chk("bp_accept_gap", 32'(acc_t.size()), 32'd2);
        if (str_t.size() >= 1 && acc_t.size() >= 1)
            chk("bp_strobe_latency", 32'(str_t[0] - acc_t[0]), 32'd19);
        else chk("bp_strobe_latency", 32'(str_t.size()), 32'd1);
        repeat (25) @(negedge clk);

        // block averager over 4 differences
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        nph = 32'h0;
        for (int k = 1; k <= 9; k++) begin
            nco_iq(nph, si, sq);
            send(si, sq, lat, ph, fv0, fo0, fv2, fo2);
            chk($sformatf("avg_valid%0d", k), 32'(fv2), 32'((k > 1) && ((k - 1) % 4 == 0)));
            chk($sformatf("avg_direct_valid%0d", k), 32'(fv0), 32'(k > 1));
            if ((k > 1) && ((k - 1) % 4 == 0))
                chk_tol($sformatf("avg_freq%0d", k), fo2, 32'h0080_0000, 1048576);
            nph = nph + 32'h0080_0000;
        end

        // reset during ITERATE aborts the sample and clears priming
        @(negedge clk);
        drive(1'b1, 17'sd0, 17'sd32767);
        @(negedge clk);
        drive(1'b0, 17'sd0, 17'sd0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_in_ready", 32'(b0.in_ready), 32'd1);
        chk("abort_phase_cleared", b0.phase_out, 32'h0);
        chk("abort_freq_cleared", b0.freq_out, 32'h0);
        strobes = 0;
        for (int t = 0; t < 25; t++) begin
            @(negedge clk);
            if (b0.phase_strobe === 1'b1) strobes++;
        end
        chk("abort_no_strobe", 32'(strobes), 32'd0);
        send(17'sd30000, 17'sd0, lat, ph, fv0, fo0, fv2, fo2);
        chk("abort_first_unprimed", 32'(fv0), 32'd0);
        send(17'sd0, 17'sd30000, lat, ph, fv0, fo0, fv2, fo2);
        chk("abort_second_valid", 32'(fv0), 32'd1);
        chk_tol("abort_second_freq", fo0, 32'h4000_0000, 262144);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
